crack_sched: RTL and testbench

//   Keyspace scheduler for NUM_CORES crack cores. Splits keys [base_key, 24'hFFFFFF] into CHUNK-key slices and hands each

---
 rtl/crack_sched_if.sv | 39 +++
 rtl/crack_sched.sv | 143 ++++++++++++++
 tb/tb_crack_sched.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/crack_sched_if.sv
// Requester and crack-core bundle for crack_sched. The slave modport is the
// scheduler's view and the master modport is the requester/core-array view.
interface crack_sched_if #(
   parameter int unsigned NUM_CORES = 2
);
   logic                      en;
   logic                      rdy;
   logic [23:0]               base_key;
   logic [23:0]               key;
   logic                      key_valid;
   logic                      done;
   logic [NUM_CORES-1:0]      core_en;
   logic [24*NUM_CORES-1:0]   core_start_key;
   logic [24*NUM_CORES-1:0]   core_end_key;
   logic [NUM_CORES-1:0]      core_abort;
   logic [NUM_CORES-1:0]      core_rdy;
   logic [NUM_CORES-1:0]      core_key_valid;
   logic [24*NUM_CORES-1:0]   core_key;
   logic [8*NUM_CORES-1:0]    core_fpt_addr;
   logic [8*NUM_CORES-1:0]    core_fpt_wrdata;
   logic [NUM_CORES-1:0]      core_fpt_wren;
   logic [7:0]                fpt_addr;
   logic [7:0]                fpt_wrdata;
   logic                      fpt_wren;

   modport slave (
      input  en, base_key, core_rdy, core_key_valid, core_key,
             core_fpt_addr, core_fpt_wrdata, core_fpt_wren,
      output rdy, key, key_valid, done, core_en, core_start_key, core_end_key,
             core_abort, fpt_addr, fpt_wrdata, fpt_wren
   );

   modport master (
      output en, base_key, core_rdy, core_key_valid, core_key,
             core_fpt_addr, core_fpt_wrdata, core_fpt_wren,
      input  rdy, key, key_valid, done, core_en, core_start_key, core_end_key,
             core_abort, fpt_addr, fpt_wrdata, fpt_wren
   );
endinterface

// File: rtl/crack_sched.sv
// Keyspace scheduler: slices [base_key, FFFFFF] across idle crack cores, takes
// the first valid key, aborts the rest and arbitrates the shared fpt port.
module crack_sched #(
   parameter int unsigned NUM_CORES = 2,
   parameter logic [23:0] CHUNK     = 24'h4000
) (
   input  logic         clk,
   input  logic         rst,
   crack_sched_if.slave bus
);
   localparam int unsigned IW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

   typedef enum logic [1:0] {IDLE, RUN, ABORT, DONE} state_t;
   state_t state, state_nx;

   logic [24:0]          next_key;
   logic [NUM_CORES-1:0] busy;
   logic [1:0]           holdoff [NUM_CORES];
   logic                 lock;
   logic [IW-1:0]        owner;

   logic                 accept, found, disp_hit, dispatch, exhaust;
   logic [NUM_CORES-1:0] comp;
   logic [IW-1:0]        win_idx, disp_idx;
   logic [24:0]          slice_last;
   logic [23:0]          slice_end;
   logic                 fwd;
   logic [IW-1:0]        src;

   assign accept     = ((state == IDLE) || (state == DONE)) && bus.en;
   assign slice_last = next_key + {1'b0, CHUNK} - 25'd1;
   assign slice_end  = slice_last[24] ? '1 : slice_last[23:0];

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      comp     = '0;
      found    = 1'b0;
      win_idx  = '0;
      disp_hit = 1'b0;
      disp_idx = '0;
      for (int unsigned i = 0; i < NUM_CORES; i++) begin
         comp[i] = busy[i] && (holdoff[i] == 2'd0) && bus.core_rdy[i];
         if (!found && comp[i] && bus.core_key_valid[i]) begin
            found   = 1'b1;
            win_idx = IW'(i);
         end
         if (!disp_hit && !busy[i] && bus.core_rdy[i]) begin
            disp_hit = 1'b1;
            disp_idx = IW'(i);
         end
      end
      dispatch = (state == RUN) && !found && disp_hit && !next_key[24];
      // A core completing this cycle no longer counts as outstanding work.
      exhaust  = next_key[24] && ((busy & ~comp) == '0);
      state_nx = state;
      case (state)
         IDLE, DONE: if (bus.en) state_nx = RUN;
         RUN: begin
            if (found)        state_nx = ABORT;
            else if (exhaust) state_nx = DONE;
         end
         ABORT:   state_nx = DONE;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      fwd = 1'b0;
      src = '0;
      if (lock) begin
         fwd = bus.core_fpt_wren[owner];
         src = owner;
      end else begin
         for (int unsigned i = 0; i < NUM_CORES; i++) begin
            if (!fwd && bus.core_fpt_wren[i]) begin
               fwd = 1'b1;
               src = IW'(i);
            end
         end
      end
      bus.fpt_wren   = fwd;
      bus.fpt_addr   = fwd ? bus.core_fpt_addr[8*src +: 8]   : '0;
      bus.fpt_wrdata = fwd ? bus.core_fpt_wrdata[8*src +: 8] : '0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         next_key           <= '0;
         busy               <= '0;
         for (int unsigned i = 0; i < NUM_CORES; i++) holdoff[i] <= '0;
         bus.rdy            <= 1'b1;
         bus.key            <= '0;
         bus.key_valid      <= 1'b0;
         bus.done           <= 1'b0;
         bus.core_en        <= '0;
         bus.core_start_key <= '0;
         bus.core_end_key   <= '0;
         bus.core_abort     <= '1;
         lock               <= 1'b0;
         owner              <= '0;
      end else begin
         bus.rdy        <= (state_nx == IDLE) || (state_nx == DONE);
         bus.done       <= (state != DONE) && (state_nx == DONE);
         bus.core_en    <= '0;
         bus.core_abort <= '0;
         for (int unsigned i = 0; i < NUM_CORES; i++)
            if (holdoff[i] != 2'd0) holdoff[i] <= holdoff[i] - 2'd1;

         if (accept) begin
            next_key      <= {1'b0, bus.base_key};
            bus.key_valid <= 1'b0;
         end

         if (state == RUN) begin
            busy <= busy & ~comp;
            if (found) begin
               bus.key        <= bus.core_key[24*win_idx +: 24];
               bus.key_valid  <= 1'b1;
               bus.core_abort <= ~(NUM_CORES'(1) << win_idx);
               busy           <= '0;
            end else if (dispatch) begin
               bus.core_en[disp_idx]                 <= 1'b1;
               bus.core_start_key[24*disp_idx +: 24] <= next_key[23:0];
               bus.core_end_key[24*disp_idx +: 24]   <= slice_end;
               next_key                              <= next_key + {1'b0, CHUNK};
               busy[disp_idx]                        <= 1'b1;
               holdoff[disp_idx]                     <= 2'd2;
            end
         end
         if (state == ABORT) busy <= '0;

         if (accept) lock <= 1'b0;
         else if (!lock && fwd) begin
            lock  <= 1'b1;
            owner <= src;
         end
      end
   end
endmodule

// File: tb/tb_crack_sched.sv
// Bench for crack_sched: behavioural core stubs, dispatch scoreboard, an fpt
// vector table and hand-written search sequences.
module tb_crack_sched;
   localparam int unsigned NC = 2;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   crack_sched_if #(.NUM_CORES(NC)) bus ();
   crack_sched #(.NUM_CORES(NC), .CHUNK(24'd4)) dut (.clk(clk), .rst(rst), .bus(bus));

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Core stubs: busy for lat[i] cycles after core_en, then idle and report a
   // key if one of the targets falls inside the slice.
   int          lat [NC];
   logic [23:0] tgt [NC];
   int          cnt [NC];
   logic [23:0] s_lo [NC];
   logic [23:0] s_hi [NC];

   always @(negedge clk) begin
      for (int i = 0; i < NC; i++) begin
         if (rst || bus.core_abort[i] === 1'b1) begin
            bus.core_rdy[i]       = 1'b1;
            bus.core_key_valid[i] = 1'b0;
            bus.core_key[24*i +: 24] = '0;
            cnt[i] = 0;
         end else if (bus.core_en[i] === 1'b1) begin
            s_lo[i] = bus.core_start_key[24*i +: 24];
            s_hi[i] = bus.core_end_key[24*i +: 24];
            bus.core_rdy[i]       = 1'b0;
            bus.core_key_valid[i] = 1'b0;
            cnt[i] = lat[i];
         end else if (cnt[i] > 0) begin
            cnt[i]--;
            if (cnt[i] == 0) begin
               bus.core_rdy[i] = 1'b1;
               for (int j = 0; j < NC; j++)
                  if (tgt[j] >= s_lo[i] && tgt[j] <= s_hi[i]) begin
                     bus.core_key_valid[i]    = 1'b1;
                     bus.core_key[24*i +: 24] = tgt[j];
                  end
            end
         end
      end
   end

   typedef struct {
      int          core;
      logic [23:0] lo;
      logic [23:0] hi;
   } disp_t;
   disp_t expq [$];

   task automatic expect_disp(input int c, input logic [23:0] lo, input logic [23:0] hi);
      disp_t d;
      d.core = c;
      d.lo   = lo;
      d.hi   = hi;
      expq.push_back(d);
   endtask

   always @(posedge clk) begin
      #1;
      for (int i = 0; i < NC; i++) begin
         if (bus.core_en[i] === 1'b1) begin
            if (expq.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL disp_extra: got core %0d slice %0h..%0h expected no dispatch", i,
                        bus.core_start_key[24*i +: 24], bus.core_end_key[24*i +: 24]);
            end else begin
               disp_t e;
               e = expq.pop_front();
               check("disp_core", i, e.core);
               check("disp_start", bus.core_start_key[24*i +: 24], e.lo);
               check("disp_end", bus.core_end_key[24*i +: 24], e.hi);
            end
         end
      end
   end

   task automatic start_search(input logic [23:0] base);
      bus.base_key = base;
      bus.en = 1'b1;
      step();
      bus.en = 1'b0;
      check("rdy_drop", bus.rdy, 1'b0);
      check("kv_clear", bus.key_valid, 1'b0);
   endtask

   task automatic wait_abort();
      for (int c = 0; c < 100 && bus.core_abort == '0; c++) step();
      check("abort_seen", (bus.core_abort != '0), 1'b1);
   endtask

   typedef struct {
      logic [1:0] wren;
      logic [7:0] a0, d0, a1, d1;
      logic       exp_wren;
      logic [7:0] exp_addr, exp_data;
   } fpt_vec_t;
   fpt_vec_t vecs [6];

   task automatic apply_fpt(input fpt_vec_t v);
      bus.core_fpt_wren   = v.wren;
      bus.core_fpt_addr   = {v.a1, v.a0};
      bus.core_fpt_wrdata = {v.d1, v.d0};
      #1;
      check("fpt_wren", bus.fpt_wren, v.exp_wren);
      if (v.exp_wren) begin
         check("fpt_addr", bus.fpt_addr, v.exp_addr);
         check("fpt_data", bus.fpt_wrdata, v.exp_data);
      end
      step();
      bus.core_fpt_wren = '0;
   endtask

   initial begin
      vecs[0] = '{2'b00, 8'h01, 8'h02, 8'h03, 8'h04, 1'b0, 8'h00, 8'h00};
      vecs[1] = '{2'b10, 8'h00, 8'h00, 8'h11, 8'h22, 1'b1, 8'h11, 8'h22};
      vecs[2] = '{2'b01, 8'h33, 8'h34, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00};
      vecs[3] = '{2'b11, 8'h44, 8'h45, 8'h55, 8'h56, 1'b1, 8'h55, 8'h56};
      vecs[4] = '{2'b10, 8'h00, 8'h00, 8'h66, 8'h67, 1'b1, 8'h66, 8'h67};
      vecs[5] = '{2'b01, 8'h77, 8'h78, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00};

      rst = 1'b1;
      bus.en = 1'b0;
      bus.base_key = '0;
      bus.core_fpt_wren = '0;
      bus.core_fpt_addr = '0;
      bus.core_fpt_wrdata = '0;
      lat[0] = 2; lat[1] = 4;
      tgt[0] = 24'd6; tgt[1] = 24'd6;

      // Reset state
      step(3);
      check("rst_rdy", bus.rdy, 1'b1);
      check("rst_abort", bus.core_abort, 2'b11);
      check("rst_kv", bus.key_valid, 1'b0);
      check("rst_key", bus.key, 24'd0);
      check("rst_done", bus.done, 1'b0);
      check("rst_core_en", bus.core_en, 2'b00);
      check("rst_fpt_wren", bus.fpt_wren, 1'b0);
      rst = 1'b0;
      step();
      check("rel_abort", bus.core_abort, 2'b00);
      check("rel_rdy", bus.rdy, 1'b1);

      // Dispatch order, redispatch, ignored en/base_key, core1 finds key 6
      expect_disp(0, 24'd0, 24'd3);
      expect_disp(1, 24'd4, 24'd7);
      expect_disp(0, 24'd8, 24'd11);
      start_search(24'd0);
      step();
      bus.base_key = 24'h000100;
      bus.en = 1'b1;
      step();
      bus.en = 1'b0;
      wait_abort();
      check("t3_abort", bus.core_abort, 2'b01);
      check("t3_key", bus.key, 24'h000006);
      check("t3_kv", bus.key_valid, 1'b1);
      check("t3_rdy_abort", bus.rdy, 1'b0);
      step();
      check("t3_abort_1cyc", bus.core_abort, 2'b00);
      check("t3_done", bus.done, 1'b1);
      check("t3_rdy", bus.rdy, 1'b1);
      step();
      check("t3_done_pulse", bus.done, 1'b0);
      check("t3_key_hold", bus.key, 24'h000006);
      check("t3_kv_hold", bus.key_valid, 1'b1);
      check("t3_q_empty", expq.size(), 0);

      // Simultaneous valid completions: lowest index wins
      lat[0] = 3; lat[1] = 2;
      tgt[0] = 24'd2; tgt[1] = 24'd5;
      expect_disp(0, 24'd0, 24'd3);
      expect_disp(1, 24'd4, 24'd7);
      start_search(24'd0);
      wait_abort();
      check("t4_abort", bus.core_abort, 2'b10);
      check("t4_key", bus.key, 24'd2);
      step();
      check("t4_done", bus.done, 1'b1);
      check("t4_q_empty", expq.size(), 0);
      step();

      // Top of keyspace: saturated last slice, exhaustion without key
      lat[0] = 2; lat[1] = 2;
      tgt[0] = 24'd0; tgt[1] = 24'd0;
      expect_disp(0, 24'hFFFFFA, 24'hFFFFFD);
      expect_disp(1, 24'hFFFFFE, 24'hFFFFFF);
      start_search(24'hFFFFFA);
      for (int c = 0; c < 100 && bus.done !== 1'b1; c++) step();
      check("t5_done", bus.done, 1'b1);
      check("t5_kv", bus.key_valid, 1'b0);
      check("t5_rdy", bus.rdy, 1'b1);
      check("t5_no_abort", bus.core_abort, 2'b00);
      step(3);
      check("t5_done_pulse", bus.done, 1'b0);
      check("t5_q_empty", expq.size(), 0);

      // fpt arbitration table
      rst = 1'b1;
      step(2);
      rst = 1'b0;
      step();
      for (int v = 0; v < 6; v++) apply_fpt(vecs[v]);

      // Lock taken mid-run, cleared by reset
      lat[0] = 20; lat[1] = 20;
      tgt[0] = 24'hFFFFFF; tgt[1] = 24'hFFFFFF;
      expect_disp(0, 24'd0, 24'd3);
      expect_disp(1, 24'd4, 24'd7);
      start_search(24'd0);
      step(3);
      apply_fpt('{2'b10, 8'h00, 8'h00, 8'hA1, 8'hB1, 1'b1, 8'hA1, 8'hB1});
      apply_fpt('{2'b01, 8'hC1, 8'hD1, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00});
      rst = 1'b1;
      step();
      check("t6_rst_rdy", bus.rdy, 1'b1);
      check("t6_rst_abort", bus.core_abort, 2'b11);
      check("t6_rst_core_en", bus.core_en, 2'b00);
      check("t6_rst_kv", bus.key_valid, 1'b0);
      check("t6_rst_done", bus.done, 1'b0);
      check("t6_rst_start", bus.core_start_key, 48'd0);
      rst = 1'b0;
      step();
      apply_fpt('{2'b01, 8'hC0, 8'hD0, 8'h00, 8'h00, 1'b1, 8'hC0, 8'hD0});
      apply_fpt('{2'b10, 8'h00, 8'h00, 8'hE1, 8'hF1, 1'b0, 8'h00, 8'h00});
      step(5);
      check("t6_q_empty", expq.size(), 0);
      check("t6_idle_rdy", bus.rdy, 1'b1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
